video_pattern_gen: RTL

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_timing_pkg.sv | 20 ++
 rtl/video_timing_cnt.sv | 60 ++++++
 rtl/video_pattern_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared encodings for the video timing generator: phase states and pattern selects.
package video_timing_pkg;

   // Phase order within a line (horizontal) or a frame (vertical).
   typedef enum logic [1:0] {
      PhActive = 2'd0,
      PhFp     = 2'd1,
      PhSync   = 2'd2,
      PhBp     = 2'd3
   } phase_e;

   // Test pattern selection.
   typedef enum logic [1:0] {
      PatHRamp   = 2'd0,
      PatVRamp   = 2'd1,
      PatChecker = 2'd2,
      PatSolid   = 2'd3
   } pattern_e;

endpackage

// File: rtl/video_timing_cnt.sv
// Four-phase length counter: walks ACTIVE -> FP -> SYNC -> BP, one step per advance.
// Phase lengths must already be non-zero; wrap_o flags the last count of BP.
module video_timing_cnt
   import video_timing_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 adv_i,
   input  logic [CNT_WIDTH-1:0] active_len_i,
   input  logic [CNT_WIDTH-1:0] fp_len_i,
   input  logic [CNT_WIDTH-1:0] sync_len_i,
   input  logic [CNT_WIDTH-1:0] bp_len_i,
   output phase_e               phase_o,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 wrap_o
);

   phase_e               r_phase;
   phase_e               w_next_phase;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_len;
   logic                 w_last;

   // Select the length of the current phase and the phase that follows it.
   always_comb begin
      w_len        = active_len_i;
      w_next_phase = PhFp;
      unique case (r_phase)
         PhActive: begin w_len = active_len_i; w_next_phase = PhFp;     end
         PhFp:     begin w_len = fp_len_i;     w_next_phase = PhSync;   end
         PhSync:   begin w_len = sync_len_i;   w_next_phase = PhBp;     end
         PhBp:     begin w_len = bp_len_i;     w_next_phase = PhActive; end
         default:  begin w_len = active_len_i; w_next_phase = PhFp;     end
      endcase
   end

   assign w_last = (r_cnt == (w_len - CNT_WIDTH'(1)));

   // Count within the phase; step to the next phase on its last count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= PhActive;
         r_cnt   <= '0;
      end else if (adv_i) begin
         if (w_last) begin
            r_phase <= w_next_phase;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign phase_o = r_phase;
   assign cnt_o   = r_cnt;
   assign wrap_o  = (r_phase == PhBp) && w_last;

endmodule

// File: rtl/video_pattern_gen.sv
// Programmable video timing and test pattern generator. Configuration is shadowed at
// frame start; all outputs are registered one cycle after the internal position.
module video_pattern_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH   = 12,
   parameter int unsigned CHECK_SHIFT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic [CNT_WIDTH-1:0]  h_active_i,
   input  logic [CNT_WIDTH-1:0]  h_fp_i,
   input  logic [CNT_WIDTH-1:0]  h_sync_i,
   input  logic [CNT_WIDTH-1:0]  h_bp_i,
   input  logic [CNT_WIDTH-1:0]  v_active_i,
   input  logic [CNT_WIDTH-1:0]  v_fp_i,
   input  logic [CNT_WIDTH-1:0]  v_sync_i,
   input  logic [CNT_WIDTH-1:0]  v_bp_i,
   input  logic [1:0]            pattern_i,
   input  logic [DATA_WIDTH-1:0] solid_i,
   output logic [DATA_WIDTH-1:0] do_o,
   output logic                  de_o,
   output logic                  hs_o,
   output logic                  vs_o,
   output logic                  sof_o
);

   // Zero-length phases run for one cycle/line.
   function automatic logic [CNT_WIDTH-1:0] fix_len(input logic [CNT_WIDTH-1:0] len);
      return (len == '0) ? CNT_WIDTH'(1) : len;
   endfunction

   logic [CNT_WIDTH-1:0]  r_h_active, r_h_fp, r_h_sync, r_h_bp;
   logic [CNT_WIDTH-1:0]  r_v_active, r_v_fp, r_v_sync, r_v_bp;
   pattern_e              r_pattern;
   logic [DATA_WIDTH-1:0] r_solid;
   logic                  r_run;

   phase_e                w_h_phase, w_v_phase;
   logic [CNT_WIDTH-1:0]  w_h_cnt, w_v_cnt;
   logic                  w_h_wrap, w_v_wrap;
   logic                  w_boundary;
   logic                  w_de, w_hs, w_vs, w_sof;
   logic [DATA_WIDTH-1:0] w_pix;

   // Idle counts as a frame boundary, so en_i is watched every cycle while stopped.
   assign w_boundary = ~r_run | (w_h_wrap & w_v_wrap);

   // Shadow configuration, refreshed only at frame boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_active <= CNT_WIDTH'(1);
         r_h_fp     <= CNT_WIDTH'(1);
         r_h_sync   <= CNT_WIDTH'(1);
         r_h_bp     <= CNT_WIDTH'(1);
         r_v_active <= CNT_WIDTH'(1);
         r_v_fp     <= CNT_WIDTH'(1);
         r_v_sync   <= CNT_WIDTH'(1);
         r_v_bp     <= CNT_WIDTH'(1);
         r_pattern  <= PatHRamp;
         r_solid    <= '0;
      end else if (w_boundary) begin
         r_h_active <= fix_len(h_active_i);
         r_h_fp     <= fix_len(h_fp_i);
         r_h_sync   <= fix_len(h_sync_i);
         r_h_bp     <= fix_len(h_bp_i);
         r_v_active <= fix_len(v_active_i);
         r_v_fp     <= fix_len(v_fp_i);
         r_v_sync   <= fix_len(v_sync_i);
         r_v_bp     <= fix_len(v_bp_i);
         r_pattern  <= pattern_e'(pattern_i);
         r_solid    <= solid_i;
      end
   end

   // Run flag: decides at each frame boundary whether another frame follows.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run <= 1'b0;
      end else if (w_boundary) begin
         r_run <= en_i;
      end
   end

   video_timing_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_h_cnt (
      .clk          (clk),
      .rst          (rst),
      .adv_i        (r_run),
      .active_len_i (r_h_active),
      .fp_len_i     (r_h_fp),
      .sync_len_i   (r_h_sync),
      .bp_len_i     (r_h_bp),
      .phase_o      (w_h_phase),
      .cnt_o        (w_h_cnt),
      .wrap_o       (w_h_wrap)
   );

   video_timing_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_v_cnt (
      .clk          (clk),
      .rst          (rst),
      .adv_i        (r_run & w_h_wrap),
      .active_len_i (r_v_active),
      .fp_len_i     (r_v_fp),
      .sync_len_i   (r_v_sync),
      .bp_len_i     (r_v_bp),
      .phase_o      (w_v_phase),
      .cnt_o        (w_v_cnt),
      .wrap_o       (w_v_wrap)
   );

   // Decode the current position into sync flags and pixel value.
   always_comb begin
      w_de  = (w_h_phase == PhActive) && (w_v_phase == PhActive);
      w_hs  = (w_h_phase == PhSync);
      w_vs  = (w_v_phase == PhSync);
      w_sof = w_de && (w_h_cnt == '0) && (w_v_cnt == '0);
      w_pix = '0;
      if (w_de) begin
         unique case (r_pattern)
            PatHRamp:   w_pix = DATA_WIDTH'(w_h_cnt);
            PatVRamp:   w_pix = DATA_WIDTH'(w_v_cnt);
            PatChecker: w_pix = (w_h_cnt[CHECK_SHIFT] ^ w_v_cnt[CHECK_SHIFT]) ? '1 : '0;
            PatSolid:   w_pix = r_solid;
            default:    w_pix = '0;
         endcase
      end
   end

   // Output register; forced low while idle or in reset.
   always_ff @(posedge clk) begin
      if (rst || !r_run) begin
         do_o  <= '0;
         de_o  <= 1'b0;
         hs_o  <= 1'b0;
         vs_o  <= 1'b0;
         sof_o <= 1'b0;
      end else begin
         do_o  <= w_pix;
         de_o  <= w_de;
         hs_o  <= w_hs;
         vs_o  <= w_vs;
         sof_o <= w_sof;
      end
   end

endmodule
